sync_prom_seq: RTL and testbench



---
 rtl/sync_prom_seq.sv | 115 +++++++++++
 tb/tb_sync_prom_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_prom_seq.sv
// Video timing sequencer for the vsync PROM.
// Shares the PROM read port with a debug requester during hblank.
module sync_prom_seq #(
  parameter int H_TOTAL       = 384,
  parameter int H_BLANK_START = 256,
  parameter int HSYNC_START   = 288,
  parameter int HSYNC_END     = 320
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [8:0] hcount,
  output logic [7:0] vcount,
  output logic       hblank,
  output logic       hsync,
  output logic       vblank,
  output logic       vsync,
  output logic       vint,
  output logic [7:0] prom_a,
  output logic       prom_e1,
  output logic       prom_e2,
  input  logic [3:0] prom_d,
  input  logic       dbg_req,
  input  logic [7:0] dbg_addr,
  output logic       dbg_ack,
  output logic [3:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_WIN  = 9'(H_TOTAL - 4);
  localparam logic [8:0] H_BS   = 9'(H_BLANK_START);
  localparam logic [8:0] H_SS   = 9'(HSYNC_START);
  localparam logic [8:0] H_SE   = 9'(HSYNC_END);

  logic [1:0] state;
  logic       line_int;
  logic       en;
  logic       wrap;
  logic       grant;
  logic [8:0] hnext;
  logic [7:0] vnext;

  assign vnext = vcount + 8'd1;
  assign wrap  = pix_ce && (hcount == H_LAST);
  assign hnext = wrap ? 9'd0 : hcount + 9'd1;

  // The window ends 3 counts before wrap so the PROM is back on vnext in time.
  assign grant = (state == S_IDLE) && dbg_req && !dbg_ack
              && hblank && (hcount <= H_WIN);

  assign prom_a  = (state == S_RD) ? dbg_addr : vnext;
  assign prom_e1 = en;
  assign prom_e2 = en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en <= 1'b0;
    end else begin
      en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount   <= 9'd0;
      vcount   <= 8'd0;
      hblank   <= 1'b0;
      hsync    <= 1'b0;
      vblank   <= 1'b0;
      vsync    <= 1'b0;
      line_int <= 1'b0;
      vint     <= 1'b0;
    end else begin
      vint <= wrap && prom_d[0] && !line_int;
      if (pix_ce) begin
        hcount <= hnext;
        hblank <= hnext >= H_BS;
        hsync  <= (hnext >= H_SS) && (hnext < H_SE);
      end
      if (wrap) begin
        vcount   <= vnext;
        vblank   <= prom_d[2];
        vsync    <= prom_d[1];
        line_int <= prom_d[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      dbg_ack  <= 1'b0;
      dbg_data <= 4'd0;
    end else begin
      dbg_ack <= (state == S_CAP);
      unique case (1'b1)
        state == S_RD: begin
          state <= S_CAP;
        end
        state == S_CAP: begin
          state    <= S_IDLE;
          dbg_data <= prom_d;
        end
        default: begin
          state <= grant ? S_RD : S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_prom_seq.sv
// Directed bench for sync_prom_seq with a registered PROM model.
// Uses a short line so whole frames fit in a small cycle budget.
module tb_sync_prom_seq;

  localparam int HT = 48;
  localparam int HB = 32;
  localparam int HS = 36;
  localparam int HE = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic       dbg_req = 1'b0;
  logic [7:0] dbg_addr = 8'h00;
  logic [3:0] prom_d = 4'h0;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic [7:0] prom_a;
  logic       hblank, hsync, vblank, vsync, vint;
  logic       prom_e1, prom_e2, dbg_ack;
  logic [3:0] dbg_data;

  int ncmp = 0;
  int nbad = 0;
  int div = 1;
  int ph = 0;
  int n, vcnt, wraps;
  logic [7:0] pv;
  logic [8:0] phc;

  sync_prom_seq #(
    .H_TOTAL(HT), .H_BLANK_START(HB),
    .HSYNC_START(HS), .HSYNC_END(HE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hcount(hcount), .vcount(vcount),
    .hblank(hblank), .hsync(hsync),
    .vblank(vblank), .vsync(vsync), .vint(vint),
    .prom_a(prom_a), .prom_e1(prom_e1), .prom_e2(prom_e2),
    .prom_d(prom_d),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // 2B contents: vblank 0xdc..0xff, vsync 0xfa..0xfd, int on 0x5e..0x5f
  function automatic logic [3:0] rom(input logic [7:0] a);
    rom = {1'b0, a >= 8'hdc, (a >= 8'hfa) && (a <= 8'hfd),
           (a == 8'h5e) || (a == 8'h5f)};
  endfunction

  always @(posedge clk) prom_d <= rom(prom_a);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ph++;
    pix_ce = (ph % div) == 0;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_hc"}, hcount, 0);
    chk({tag, "_vc"}, vcount, 0);
    chk({tag, "_hb"}, hblank, 0);
    chk({tag, "_hs"}, hsync, 0);
    chk({tag, "_vb"}, vblank, 0);
    chk({tag, "_vs"}, vsync, 0);
    chk({tag, "_vi"}, vint, 0);
    chk({tag, "_ack"}, dbg_ack, 0);
    chk({tag, "_dat"}, dbg_data, 0);
    chk({tag, "_pa"}, prom_a, 8'h01);
    chk({tag, "_e1"}, prom_e1, 0);
    chk({tag, "_e2"}, prom_e2, 0);
  endtask

  task automatic wait_rd(input logic [7:0] a);
    for (int i = 0; i < 600 && prom_a != a; i++) tick();
    chk("rd_grant", prom_a, a);
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] d);
    int k = 0;
    while (!dbg_ack && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, 2);
    chk({tag, "_data"}, dbg_data, d);
    dbg_req = 1'b0;
    tick();
    chk({tag, "_ack1"}, dbg_ack, 0);
  endtask

  task automatic wait_line(input logic [7:0] v, input logic [8:0] h);
    for (int i = 0; i < 20000 && !(vcount == v && hcount == h); i++)
      tick();
    chk("reach_v", vcount, v);
    chk("reach_h", hcount, h);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst_chk("rst");

    // Slow pixel clock: 1 in 4
    div = 4;
    ph = 0;
    pix_ce = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("en_e1", prom_e1, 1);
    chk("en_e2", prom_e2, 1);
    for (int i = 0; i < 2000 && vcount != 8'd1; i++) tick();
    n = 0;
    while (vcount == 8'd1 && n < 1000) begin
      tick();
      n++;
    end
    chk("slow_line_clks", n, 4 * HT);
    vcnt = 0;
    for (int i = 0; i < 20000 && vcount != 8'h5e; i++) begin
      tick();
      vcnt += int'(vint);
    end
    chk("slow_v5e", vcount, 8'h5e);
    chk("slow_vint_on", vint, 1);
    tick();
    chk("slow_vint_off", vint, 0);
    for (int i = 0; i < 2000 && vcount != 8'h60; i++) begin
      tick();
      vcnt += int'(vint);
    end
    chk("slow_vint_once", vcnt, 1);
    for (int i = 0; i < 400 && hcount != 9'd5; i++) tick();
    dbg_req = 1'b1;
    dbg_addr = 8'hdc;
    wait_rd(8'hdc);
    chk("slow_rd_hb", hblank, 1);
    wait_ack("slow_dbg", 4'b0100);

    // Fast pixel clock, two passes through the frame
    reset_n = 1'b0;
    #1;
    rst_chk("rst2");
    div = 1;
    ph = 0;
    pix_ce = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    pv = vcount;
    phc = hcount;
    wraps = 0;
    vcnt = 0;
    for (int i = 0; i < 20000 && !(wraps == 1 && vcount == 8'h60); i++) begin
      tick();
      chk("hblank", hblank, hcount >= HB);
      chk("hsync", hsync, (hcount >= HS) && (hcount < HE));
      if (vcount != pv) begin
        chk("vstep", vcount, 8'(pv + 8'd1));
        chk("hzero", hcount, 0);
        chk("vblank", vblank, vcount >= 8'hdc);
        chk("vsync", vsync, (vcount >= 8'hfa) && (vcount <= 8'hfd));
        chk("vint", vint, vcount == 8'h5e);
        if (vcount == 8'h00) begin
          chk("hwrap", phc, HT - 1);
          chk("vint_frame", vcnt, 1);
          vcnt = 0;
          wraps++;
        end
      end else begin
        chk("vint_idle", vint, 0);
      end
      vcnt += int'(vint);
      pv = vcount;
      phc = hcount;
    end
    chk("frame2_v", vcount, 8'h60);
    chk("frame2_vint", vcnt, 1);

    // Late request on 0xdb is deferred past the vblank edge
    wait_line(8'hdb, 9'(HT - 3));
    dbg_req = 1'b1;
    dbg_addr = 8'h5f;
    wait_rd(8'h5f);
    chk("late_v", vcount, 8'hdc);
    chk("late_h", hcount, HB + 1);
    chk("late_vb", vblank, 1);
    chk("late_vs", vsync, 0);
    wait_ack("late_dbg", 4'b0001);

    // Early request on 0xf9 waits for hblank, vsync edge intact
    wait_line(8'hf9, 9'd10);
    dbg_req = 1'b1;
    dbg_addr = 8'hdc;
    wait_rd(8'hdc);
    chk("early_v", vcount, 8'hf9);
    chk("early_h", hcount, HB + 1);
    wait_ack("early_dbg", 4'b0100);
    for (int i = 0; i < 100 && vcount != 8'hfa; i++) tick();
    chk("early_next_v", vcount, 8'hfa);
    chk("early_next_vs", vsync, 1);
    chk("early_next_vb", vblank, 1);

    // Reset in the middle of a debug read
    wait_line(8'hfa, 9'd10);
    dbg_req = 1'b1;
    dbg_addr = 8'h5f;
    wait_rd(8'h5f);
    #1;
    reset_n = 1'b0;
    dbg_req = 1'b0;
    #1;
    rst_chk("rst_rd");
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(dbg_ack);
    end
    chk("abort_noack", n, 0);
    chk("abort_pa", prom_a, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
